// File: rtl/mult_arbiter_if.sv
// Requester-side and multiplier-side signals shared by mult_arbiter and its environment.
// The slave modport is the arbiter's view; master is the environment's view.
interface mult_arbiter_if #(
   parameter int NREQ = 2,
   parameter int W    = 4
);
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] a_bus;
   logic [NREQ*W-1:0] b_bus;
   logic [NREQ-1:0]   ack;
   logic [2*W-1:0]    res;
   logic              err;
   logic              busy;
   logic [NREQ-1:0]   gnt;
   logic              m_valid;
   logic [W-1:0]      m_A;
   logic [W-1:0]      m_B;
   logic [2*W-1:0]    m_prod;
   logic              m_DONE;

   modport slave (
      input  req, a_bus, b_bus, m_prod, m_DONE,
      output ack, res, err, busy, gnt, m_valid, m_A, m_B
   );

   modport master (
      output req, a_bus, b_bus, m_prod, m_DONE,
      input  ack, res, err, busy, gnt, m_valid, m_A, m_B
   );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier between NREQ requesters,
// with a watchdog that answers with err=1 if the multiplier never raises DONE.
module mult_arbiter #(
   parameter int NREQ    = 2,
   parameter int W       = 4,
   parameter int TIMEOUT = 64
) (
   input logic            clk,
   input logic            rst,
   mult_arbiter_if.slave  bus
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

   state_e            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [IW-1:0]     last_q, last_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [W-1:0]      a_q, a_d;
   logic [W-1:0]      b_q, b_d;
   logic [2*W-1:0]    res_q, res_d;
   logic              err_q, err_d;
   logic [TW-1:0]     timer_q, timer_d;

   logic              hi_hit;
   logic [IW-1:0]     hi_idx, lo_idx, pick_idx;

   // Lowest set request above last wins; otherwise wrap to the lowest set request overall.
   always_comb begin
      hi_hit = 1'b0;
      hi_idx = '0;
      lo_idx = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (bus.req[i]) begin
            if (IW'(i) > last_q) begin
               hi_hit = 1'b1;
               hi_idx = IW'(i);
            end else begin
               lo_idx = IW'(i);
            end
         end
      end
      pick_idx = hi_hit ? hi_idx : lo_idx;
   end

   // NOTE: every _d starts from its _q so no path through this block can infer a latch.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      err_d   = err_q;
      timer_d = timer_q;
      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               idx_d   = pick_idx;
               gnt_d   = NREQ'(1) << pick_idx;
               a_d     = bus.a_bus[int'(pick_idx) * W +: W];
               b_d     = bus.b_bus[int'(pick_idx) * W +: W];
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            timer_d = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (bus.m_DONE) begin
               res_d   = bus.m_prod;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               res_d   = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         RESP: begin
            last_d  = idx_q;
            gnt_d   = '0;
            err_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         last_q  <= IW'(NREQ - 1);
         gnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         err_q   <= err_d;
         timer_q <= timer_d;
      end
   end

   assign bus.ack     = (state_q == RESP) ? gnt_q : '0;
   assign bus.res     = res_q;
   assign bus.err     = err_q;
   assign bus.busy    = (state_q != IDLE);
   assign bus.gnt     = gnt_q;
   assign bus.m_valid = (state_q == ISSUE);
   assign bus.m_A     = a_q;
   assign bus.m_B     = b_q;

endmodule
